// File: rtl/interrupt_pkg.sv
// Shared constants and FSM state type for the interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package interrupt_pkg;

    localparam int N_SRC = 4;
    localparam int ID_W  = $clog2(N_SRC);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder: returns the highest-index asserted request bit.
// Latency: combinational, zero cycles.
// Backpressure: none; vld_o=0 when no request bit is set (id_o is then 0).
//
// Ports:
//   req_i  request vector, bit i = source i
//   id_o   index of the highest set bit of req_i
//   vld_o  at least one bit of req_i is set
module irq_prio_enc
    import interrupt_pkg::*;
(
    input  logic [N_SRC-1:0] req_i,
    output logic [ID_W-1:0]  id_o,
    output logic             vld_o
);

    // Ascending scan: a later (higher) index overwrites a lower one.
    always_comb begin
        id_o  = '0;
        vld_o = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req_i[i]) begin
                id_o  = ID_W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing interrupt controller with mask, fixed priority and req/ack/eoi handshake to the CPU.
// Latency: irq rise -> pending at the same edge, int_req one edge later; ack/eoi take effect at the sampling edge.
// Backpressure: int_req holds with a frozen int_id until int_ack; new edges only accumulate in pending meanwhile.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   irq             peripheral request levels (rising edge captured)
//   mask_we/in      mask register write (1 = source disabled)
//   int_ack, eoi    CPU accept / end-of-interrupt strobes
//   int_req, int_id, in_service, pending   registered status outputs
//   any_pending     combinational OR of unmasked pending bits
module interrupt_controller
    import interrupt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_in,
    input  logic             int_ack,
    input  logic             eoi,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic             in_service,
    output logic [N_SRC-1:0] pending,
    output logic             any_pending
);

    state_t           state_q, state_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q;
    logic [ID_W-1:0]  int_id_q, int_id_d;
    logic             int_req_q;
    logic             in_service_q;

    logic [N_SRC-1:0] irq_rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] ack_clr;
    logic [ID_W-1:0]  sel_id;
    logic             sel_vld;

    assign irq_rise    = irq & ~irq_prev_q;
    assign eligible    = pending_q & ~mask_q;
    assign any_pending = |eligible;

    irq_prio_enc u_prio_enc (
        .req_i (eligible),
        .id_o  (sel_id),
        .vld_o (sel_vld)
    );

    // int_id only moves when leaving IDLE, so it stays frozen through REQ and
    // SERVICE regardless of later arrivals or mask writes.
    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        ack_clr  = '0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    int_id_d = sel_id;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    ack_clr = N_SRC'(1) << int_id_q;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set after clear: a new edge on the acknowledged bit keeps it pending.
    assign pending_d = (pending_q & ~ack_clr) | irq_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            int_id_q     <= '0;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq;
            pending_q    <= pending_d;
            int_id_q     <= int_id_d;
            int_req_q    <= (state_d == REQ);
            in_service_q <= (state_d == SERVICE);
            if (mask_we) begin
                mask_q <= mask_in;
            end
        end
    end

    assign int_req    = int_req_q;
    assign int_id     = int_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule
